// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED PWM driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: PWM counter width, full-duty value and the display mode encoding
// as it appears on the mode PIO output.
`timescale 1ns/1ps

package led_drv_pkg;

    localparam int PWM_BITS = 8;

    // Duty value that forces the output permanently on; without this the
    // counter compare could never reach 100 % duty with an 8-bit counter.
    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'd255;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, 8-bit PWM counter and blink/chase step counter.
// Latency: outputs are combinational decodes of the counter registers.
// Backpressure: none; free-running from reset release.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   pwm_cnt       : current PWM counter value (0..255)
//   tick          : prescaler terminal count, PWM counter advances on it
//   period_end    : last clock of a PWM period (tick while pwm_cnt == 255)
//   step_end      : period_end of the last period in a blink/chase step
`timescale 1ns/1ps

module led_pwm_timebase
    import led_drv_pkg::*;
#(
    parameter int PWM_DIV      = 195,
    parameter int STEP_PERIODS = 250
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                tick,
    output logic                period_end,
    output logic                step_end
);

    // Counter widths; a divider of 0 or a single step period still needs a
    // one-bit register so the logic stays uniform.
    localparam int PRE_W  = (PWM_DIV > 0)      ? $clog2(PWM_DIV + 1)   : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    logic [PRE_W-1:0]    pre_cnt_q,  pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;

    always_comb begin
        tick       = (pre_cnt_q == PRE_LAST);
        period_end = tick && (pwm_cnt_q == DUTY_FULL);
        step_end   = period_end && (step_cnt_q == STEP_LAST);

        pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);

        pwm_cnt_d  = pwm_cnt_q;
        if (tick) begin
            // Natural 8-bit wrap 255 -> 0.
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end

        step_cnt_d = step_cnt_q;
        if (step_end) begin
            step_cnt_d = '0;
        end else if (period_end) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED driver: PWM dimming plus static/blink/chase display of the LED PIO word.
// Latency: led_out is registered, one clock after counter/shadow state.
// Backpressure: none; inputs are sampled only at PWM period boundaries.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   pattern_in     : LED pattern word from the PIO
//   brightness_in  : global duty, 0 = off, 255 = fully on
//   mode_in        : 0 static, 1 blink, 2 chase, 3 reserved (shown as static)
//   led_out        : registered active-high LED drive
//   period_strobe  : one-clock pulse the cycle after each PWM period end
//
// Build option: define LED_GAMMA_EN to square the brightness (b*b >> 8) for
// perceptually linear dimming; 255 remains fully on either way.
`timescale 1ns/1ps

module led_pwm_driver
    import led_drv_pkg::*;
#(
    parameter int NUM_LEDS     = 10,
    parameter int PWM_DIV      = 195,
    parameter int STEP_PERIODS = 250
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic [7:0]          brightness_in,
    input  logic [1:0]          mode_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_strobe
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick_unused;
    logic                period_end;
    logic                step_end;

    // The prescaler tick is only needed inside the timebase.
    led_pwm_timebase #(
        .PWM_DIV      (PWM_DIV),
        .STEP_PERIODS (STEP_PERIODS)
    ) u_timebase (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_cnt    (pwm_cnt),
        .tick       (tick_unused),
        .period_end (period_end),
        .step_end   (step_end)
    );

    // Shadow copies of the PIO inputs; everything downstream sees only these
    // so a software write mid-period cannot glitch the current PWM period.
    logic [NUM_LEDS-1:0] pattern_sh_q, pattern_sh_d;
    logic [7:0]          bright_sh_q,  bright_sh_d;
    mode_e               mode_sh_q,    mode_sh_d;

    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] chase_q, chase_d;
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;
    logic                period_strobe_q, period_strobe_d;

    logic [7:0]          duty;
    mode_e               mode_in_e;
    logic [NUM_LEDS-1:0] lit;
    logic                pwm_on;

`ifdef LED_GAMMA_EN
    // Squared duty, computed once at the period boundary from the value being
    // latched so the compare path never sees the multiplier.
    logic [7:0]  duty_q, duty_d;
    logic [15:0] bright_ext;

    always_comb begin
        bright_ext = {8'd0, brightness_in};
        duty_d     = duty_q;
        if (period_end) begin
            duty_d = 8'((bright_ext * bright_ext) >> 8);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty = duty_q;
`else
    assign duty = bright_sh_q;
`endif

    // Shadow latch plus blink/chase state updates at the period boundary.
    always_comb begin
        mode_in_e    = mode_e'(mode_in);
        pattern_sh_d = pattern_sh_q;
        bright_sh_d  = bright_sh_q;
        mode_sh_d    = mode_sh_q;
        phase_d      = phase_q;
        chase_d      = chase_q;

        if (period_end) begin
            pattern_sh_d = pattern_in;
            bright_sh_d  = brightness_in;
            mode_sh_d    = mode_in_e;

            // Entering blink always starts with the dark half.
            if ((mode_in_e == MODE_BLINK) && (mode_sh_q != MODE_BLINK)) begin
                phase_d = 1'b0;
            end else if (step_end) begin
                phase_d = ~phase_q;
            end

            // A fresh pattern (or entering chase) restarts the chase from the
            // pattern itself; this wins over a rotate on the same edge.
            if ((mode_in_e == MODE_CHASE) &&
                ((mode_sh_q != MODE_CHASE) || (pattern_in != pattern_sh_q))) begin
                chase_d = pattern_in;
            end else if (step_end) begin
                chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
            end
        end
    end

    // Pattern selection and PWM gating.
    always_comb begin
        unique case (mode_sh_q)
            MODE_BLINK: lit = phase_q ? pattern_sh_q : '0;
            MODE_CHASE: lit = chase_q;
            default:    lit = pattern_sh_q;
        endcase

        // Full-scale brightness bypasses the compare, which alone tops out
        // at 255/256 duty.
        pwm_on = (bright_sh_q == DUTY_FULL) || (pwm_cnt < duty);

        led_out_d       = lit & {NUM_LEDS{pwm_on}};
        period_strobe_d = period_end;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_sh_q    <= '0;
            bright_sh_q     <= '0;
            mode_sh_q       <= MODE_STATIC;
            phase_q         <= 1'b0;
            chase_q         <= '0;
            led_out_q       <= '0;
            period_strobe_q <= 1'b0;
        end else begin
            pattern_sh_q    <= pattern_sh_d;
            bright_sh_q     <= bright_sh_d;
            mode_sh_q       <= mode_sh_d;
            phase_q         <= phase_d;
            chase_q         <= chase_d;
            led_out_q       <= led_out_d;
            period_strobe_q <= period_strobe_d;
        end
    end

    assign led_out       = led_out_q;
    assign period_strobe = period_strobe_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver with a short timebase
// (PWM_DIV=0, STEP_PERIODS=2: one PWM period = 256 clocks, one step = 2 periods).
// An event-level reference model is compared every clock; directed literal
// expectations pin the model and the boundary cases.
`timescale 1ns/1ps

module tb_led_pwm_driver;

    localparam int NL  = 10;
    localparam int DIV = 0;
    localparam int SP  = 2;
    localparam int PER = 256 * (DIV + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NL-1:0] pattern_in = '0;
    logic [7:0]    brightness_in = '0;
    logic [1:0]    mode_in = '0;
    logic [NL-1:0] led_out;
    logic          period_strobe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .NUM_LEDS     (NL),
        .PWM_DIV      (DIV),
        .STEP_PERIODS (SP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pattern_in    (pattern_in),
        .brightness_in (brightness_in),
        .mode_in       (mode_in),
        .led_out       (led_out),
        .period_strobe (period_strobe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // State as seen between period boundaries: latched inputs, blink phase,
    // current chase word and the clock count since reset release.
    int            m_n;
    logic [NL-1:0] m_pat, m_chase, m_lit, exp_led;
    logic [7:0]    m_bri, m_duty;
    logic [1:0]    m_mode;
    logic          m_phase, exp_strobe, m_on;
    int            m_pwm, m_gamma;
    bit            m_step;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_n = 0; m_pat = '0; m_chase = '0; m_bri = '0; m_duty = '0;
            m_mode = '0; m_phase = 1'b0;
            #1;
            chk("model_reset_led", 32'(led_out), 32'd0);
            chk("model_reset_strobe", 32'(period_strobe), 32'd0);
        end else begin
            m_n++;
            // PWM value seen by the output register on this edge.
            m_pwm = ((m_n - 1) / (DIV + 1)) % 256;
            case (m_mode)
                2'd1:    m_lit = m_phase ? m_pat : '0;
                2'd2:    m_lit = m_chase;
                default: m_lit = m_pat;
            endcase
            m_on       = (m_bri == 8'd255) || (m_pwm < int'(m_duty));
            exp_led    = m_on ? m_lit : '0;
            exp_strobe = (m_n % PER) == 0;
            if (exp_strobe) begin
                m_step = ((m_n / PER) % SP) == 0;
                if (mode_in == 2'd1 && m_mode != 2'd1) m_phase = 1'b0;
                else if (m_step) m_phase = ~m_phase;
                if (mode_in == 2'd2 && (m_mode != 2'd2 || pattern_in != m_pat)) m_chase = pattern_in;
                else if (m_step) m_chase = {m_chase[NL-2:0], m_chase[NL-1]};
                m_pat  = pattern_in;
                m_bri  = brightness_in;
                m_mode = mode_in;
`ifdef LED_GAMMA_EN
                m_gamma = int'(brightness_in) * int'(brightness_in);
                m_duty  = 8'(m_gamma >> 8);
`else
                m_duty  = brightness_in;
`endif
            end
            #1;
            chk("model_led", 32'(led_out), 32'(exp_led));
            chk("model_strobe", 32'(period_strobe), 32'(exp_strobe));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic adv(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk); #1; c++;
        end while (!period_strobe && c < 600);
        chk(name, 32'(period_strobe), 32'd1);
    endtask

    task automatic wait_change(input string name, output int cycles);
        logic [NL-1:0] prev;
        int c;
        prev = led_out;
        c = 0;
        do begin
            @(posedge clk); #1; c++;
        end while (led_out == prev && c < 600);
        chk(name, 32'(led_out != prev), 32'd1);
        cycles = c;
    endtask

    logic [NL-1:0] gamma_exp;
    int cyc;
    int r;

    initial begin
`ifdef LED_GAMMA_EN
        gamma_exp = '0;
`else
        gamma_exp = 10'h3FF;
`endif
        // Reset and first period.
        mode_in = 2'd0; pattern_in = 10'h2A5; brightness_in = 8'd64;
        #1 reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_led", 32'(led_out), 32'd0);
        chk("reset_strobe", 32'(period_strobe), 32'd0);
        reset_n = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!period_strobe && cyc < 600);
        chk("first_strobe_cycles", 32'(cyc), 32'd256);

        // Static, brightness 64.
        adv(1);  chk("static64_pwm0",  32'(led_out), 32'h2A5);
        adv(63); chk("static64_pwm63", 32'(led_out), 32'h2A5);
        adv(1);  chk("static64_pwm64", 32'(led_out), 32'h000);

        // Static, brightness 255 then 0.
        brightness_in = 8'd255;
        wait_strobe("strobe_b255");
        adv(1);   chk("static255_pwm0",   32'(led_out), 32'h2A5);
        adv(200); chk("static255_pwm200", 32'(led_out), 32'h2A5);
        brightness_in = 8'd0;
        wait_strobe("strobe_b0");
        adv(1);   chk("static0_pwm0",   32'(led_out), 32'h000);
        adv(254); chk("static0_pwm254", 32'(led_out), 32'h000);

        // Mid-period pattern change must wait for the next period.
        pattern_in = 10'h001; brightness_in = 8'd255;
        wait_strobe("strobe_glitch0");
        adv(101); chk("glitch_pwm100", 32'(led_out), 32'h001);
        pattern_in = 10'h3FF;
        adv(150); chk("glitch_pwm250", 32'(led_out), 32'h001);
        wait_strobe("strobe_glitch1");
        chk("glitch_at_strobe", 32'(led_out), 32'h001);
        adv(1);   chk("glitch_new", 32'(led_out), 32'h3FF);

        // Blink.
        mode_in = 2'd1; pattern_in = 10'h3FF; brightness_in = 8'd255;
        wait_strobe("strobe_blink");
        adv(1); chk("blink_entry_dark", 32'(led_out), 32'h000);
        wait_change("blink_first_on", cyc);
        chk("blink_on_val", 32'(led_out), 32'h3FF);
        wait_change("blink_off", cyc);
        chk("blink_on_len", 32'(cyc), 32'd512);
        chk("blink_off_val", 32'(led_out), 32'h000);
        wait_change("blink_on2", cyc);
        chk("blink_off_len", 32'(cyc), 32'd512);

        // Chase.
        mode_in = 2'd2; pattern_in = 10'h201;
        wait_strobe("strobe_chase");
        adv(1); chk("chase_load", 32'(led_out), 32'h201);
        wait_change("chase_step1", cyc);
        chk("chase_val1", 32'(led_out), 32'h003);
        wait_change("chase_step2", cyc);
        chk("chase_len", 32'(cyc), 32'd512);
        chk("chase_val2", 32'(led_out), 32'h006);
        for (int i = 0; i < 8; i++) wait_change("chase_stepn", cyc);
        chk("chase_wrap", 32'(led_out), 32'h201);
        pattern_in = 10'h001;
        wait_strobe("strobe_reload");
        adv(1); chk("chase_reload", 32'(led_out), 32'h001);

        // All-ones chase stays all-ones.
        pattern_in = 10'h3FF;
        wait_strobe("strobe_ones");
        adv(600); chk("chase_ones", 32'(led_out), 32'h3FF);

        // Duty 128, with and without gamma.
        mode_in = 2'd0; pattern_in = 10'h3FF; brightness_in = 8'd128;
        wait_strobe("strobe_gamma");
        adv(64); chk("b128_pwm63",  32'(led_out), 32'h3FF);
        adv(1);  chk("b128_pwm64",  32'(led_out), 32'(gamma_exp));
        adv(63); chk("b128_pwm127", 32'(led_out), 32'(gamma_exp));
        adv(1);  chk("b128_pwm128", 32'(led_out), 32'h000);

        // Asynchronous reset mid-period.
        brightness_in = 8'd255;
        wait_strobe("strobe_prerst");
        adv(10);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_out), 32'd0);
        chk("async_rst_strobe", 32'(period_strobe), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!period_strobe && cyc < 600);
        chk("rst_first_strobe", 32'(cyc), 32'd256);

        // Randomised traffic checked by the model.
        for (int it = 0; it < 30; it++) begin
            adv($urandom_range(700, 50));
            r = $urandom_range(7, 0);
            if (r == 0)      pattern_in = '0;
            else if (r == 1) pattern_in = 10'h3FF;
            else             pattern_in = NL'($urandom);
            r = $urandom_range(7, 0);
            if (r == 0)      brightness_in = 8'd0;
            else if (r == 1) brightness_in = 8'd255;
            else             brightness_in = 8'($urandom);
            if ($urandom_range(2, 0) != 0) mode_in = 2'($urandom);
        end
        adv(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
